// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants and types for the memory-mapped timer/GPIO slave.
//   - Default window base address (256-byte window).
//   - Word-aligned register offsets within the window.
//   - CTRL / STATUS bit layout and a window-decode helper.
package mmio_pkg;

  localparam logic [31:0] BASE_ADDR_DEF = 32'hFFFF_0000;

  localparam logic [7:0] OFF_GPIO_OUT = 8'h00;
  localparam logic [7:0] OFF_GPIO_IN  = 8'h04;
  localparam logic [7:0] OFF_CTRL     = 8'h08;
  localparam logic [7:0] OFF_PRESCALE = 8'h0C;
  localparam logic [7:0] OFF_COUNT    = 8'h10;
  localparam logic [7:0] OFF_COMPARE  = 8'h14;
  localparam logic [7:0] OFF_STATUS   = 8'h18;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_RELOAD_BIT  = 1;
  localparam int CTRL_IRQ_EN_BIT  = 2;
  localparam int STATUS_MATCH_BIT = 0;

  // Packed so that bit 0 is en, bit 1 auto_reload, bit 2 irq_en.
  typedef struct packed {
    logic irq_en;
    logic auto_reload;
    logic en;
  } ctrl_t;

  // True when the byte address lies in the 256-byte window starting at base.
  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
    return (addr[31:8] == base[31:8]);
  endfunction

endpackage

// File: rtl/mmio_timer_core.sv
// mmio_timer_core: prescaler plus 32-bit COUNT with COMPARE match flag.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en_i              timer enable (CTRL.en)
//   auto_reload_i     reload COUNT to 0 on match (CTRL.auto_reload)
//   prescale_i        prescale terminal value; tick every prescale_i+1 cycles
//   compare_i         COMPARE register value
//   pcnt_clr_i        restart prescaler (CPU write to CTRL or PRESCALE)
//   count_we_i        CPU write strobe for COUNT, data on count_wdata_i
//   match_clr_i       write-1-to-clear of STATUS.match
//   count_o, match_o  current COUNT and match flag
module mmio_timer_core
  import mmio_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        auto_reload_i,
  input  logic [31:0] prescale_i,
  input  logic [31:0] compare_i,
  input  logic        pcnt_clr_i,
  input  logic        count_we_i,
  input  logic [31:0] count_wdata_i,
  input  logic        match_clr_i,
  output logic [31:0] count_o,
  output logic        match_o
);

  logic [31:0] pcnt_q, pcnt_d;
  logic [31:0] count_q, count_d;
  logic        match_q, match_d;
  logic        tick_s;
  logic        hit_s;

  assign tick_s = en_i & (pcnt_q == prescale_i);
  // Match test always uses the pre-write COUNT, even if the CPU writes COUNT this cycle.
  assign hit_s  = tick_s & (count_q == compare_i);

  // Prescaler next state: held at zero while disabled or when restarted by a config write.
  always_comb begin
    pcnt_d = 32'd0;
    if (!en_i) begin
      pcnt_d = 32'd0;
    end else if (pcnt_clr_i || tick_s) begin
      pcnt_d = 32'd0;
    end else begin
      pcnt_d = pcnt_q + 32'd1;
    end
  end

  // COUNT next state: CPU write wins over the tick increment.
  always_comb begin
    count_d = count_q;
    if (count_we_i) begin
      count_d = count_wdata_i;
    end else if (hit_s && auto_reload_i) begin
      count_d = 32'd0;
    end else if (tick_s) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Match flag next state: a new match beats a coincident clear.
  always_comb begin
    match_d = match_q;
    if (hit_s) begin
      match_d = 1'b1;
    end else if (match_clr_i) begin
      match_d = 1'b0;
    end else begin
      match_d = match_q;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q  <= 32'd0;
      count_q <= 32'd0;
      match_q <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      count_q <= count_d;
      match_q <= match_d;
    end
  end

  assign count_o = count_q;
  assign match_o = match_q;

endmodule

// File: rtl/mmio_timer_gpio.sv
// mmio_timer_gpio: memory-mapped slave with GPIO out/in registers and a prescaled timer.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   mem_write, datamem_add,
//   write_data                   CPU store strobe, byte address and store data
//   io_sel                       address is inside this block's 256-byte window
//   io_readdata                  combinational read data (0 when unmapped / not selected)
//   gpio_in                      asynchronous pins, double-flop synchronised
//   gpio_out                     registered GPIO outputs
//   timer_irq                    level interrupt = STATUS.match & CTRL.irq_en
module mmio_timer_gpio
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEF,
  parameter int          GPIO_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_write,
  input  logic [31:0]           datamem_add,
  input  logic [31:0]           write_data,
  output logic                  io_sel,
  output logic [31:0]           io_readdata,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic                  timer_irq
);

  logic [GPIO_WIDTH-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_WIDTH-1:0] sync1_q, sync2_q;
  ctrl_t                 ctrl_q, ctrl_d;
  logic [31:0]           prescale_q, prescale_d;
  logic [31:0]           compare_q, compare_d;
  logic [31:0]           count_s;
  logic                  match_s;
  logic                  we_s;
  logic [7:0]            offset_s;
  logic [31:0]           rdata_s;
  logic                  unused_addr_bits;

  // Byte-lane bits are ignored: all accesses are whole words.
  assign unused_addr_bits = ^datamem_add[1:0];
  assign io_sel   = in_window(datamem_add, BASE_ADDR);
  assign offset_s = {datamem_add[7:2], 2'b00};
  assign we_s     = mem_write & io_sel;

  // Next-state for CPU-writable configuration registers.
  always_comb begin
    gpio_out_d = gpio_out_q;
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    compare_d  = compare_q;
    if (we_s) begin
      case (offset_s)
        OFF_GPIO_OUT: gpio_out_d = write_data[GPIO_WIDTH-1:0];
        OFF_CTRL:     ctrl_d     = ctrl_t'(write_data[2:0]);
        OFF_PRESCALE: prescale_d = write_data;
        OFF_COMPARE:  compare_d  = write_data;
        default:      gpio_out_d = gpio_out_q;
      endcase
    end else begin
      gpio_out_d = gpio_out_q;
    end
  end

  // Register file and the two-flop GPIO input synchroniser.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      ctrl_q     <= ctrl_t'(3'b000);
      prescale_q <= 32'd0;
      compare_q  <= 32'd0;
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      compare_q  <= compare_d;
    end
  end

  mmio_timer_core u_core (
    .clk           (clk),
    .rst           (rst),
    .en_i          (ctrl_q.en),
    .auto_reload_i (ctrl_q.auto_reload),
    .prescale_i    (prescale_q),
    .compare_i     (compare_q),
    .pcnt_clr_i    (we_s & ((offset_s == OFF_PRESCALE) | (offset_s == OFF_CTRL))),
    .count_we_i    (we_s & (offset_s == OFF_COUNT)),
    .count_wdata_i (write_data),
    .match_clr_i   (we_s & (offset_s == OFF_STATUS) & write_data[STATUS_MATCH_BIT]),
    .count_o       (count_s),
    .match_o       (match_s)
  );

  // Zero-latency read mux.
  always_comb begin
    rdata_s = 32'd0;
    if (io_sel) begin
      case (offset_s)
        OFF_GPIO_OUT: rdata_s = {{(32-GPIO_WIDTH){1'b0}}, gpio_out_q};
        OFF_GPIO_IN:  rdata_s = {{(32-GPIO_WIDTH){1'b0}}, sync2_q};
        OFF_CTRL:     rdata_s = {29'd0, ctrl_q};
        OFF_PRESCALE: rdata_s = prescale_q;
        OFF_COUNT:    rdata_s = count_s;
        OFF_COMPARE:  rdata_s = compare_q;
        OFF_STATUS:   rdata_s = {31'd0, match_s};
        default:      rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign io_readdata = rdata_s;
  assign gpio_out    = gpio_out_q;
  assign timer_irq   = match_s & ctrl_q.irq_en;

endmodule

// File: tb/tb_mmio_timer_gpio.sv
// Directed bench for mmio_timer_gpio: every expected value is hand-derived.
module tb_mmio_timer_gpio;

  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam logic [7:0]  R_OUT = 8'h00;
  localparam logic [7:0]  R_IN  = 8'h04;
  localparam logic [7:0]  R_CTL = 8'h08;
  localparam logic [7:0]  R_PRE = 8'h0C;
  localparam logic [7:0]  R_CNT = 8'h10;
  localparam logic [7:0]  R_CMP = 8'h14;
  localparam logic [7:0]  R_STS = 8'h18;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_write = 1'b0;
  logic [31:0] datamem_add = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic        io_sel;
  logic [31:0] io_readdata;
  logic [7:0]  gpio_in = 8'd0;
  logic [7:0]  gpio_out;
  logic        timer_irq;

  int total = 0;
  int bad   = 0;

  mmio_timer_gpio #(.BASE_ADDR(32'hFFFF_0000), .GPIO_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_write   (mem_write),
    .datamem_add (datamem_add),
    .write_data  (write_data),
    .io_sel      (io_sel),
    .io_readdata (io_readdata),
    .gpio_in     (gpio_in),
    .gpio_out    (gpio_out),
    .timer_irq   (timer_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] data);
    datamem_add = BASE | {24'd0, off};
    write_data  = data;
    mem_write   = 1'b1;
    @(posedge clk);
    #1;
    mem_write   = 1'b0;
    datamem_add = 32'd0;
  endtask

  task automatic chk_rd(input string tag, input logic [7:0] off, input logic [31:0] exp);
    datamem_add = BASE | {24'd0, off};
    #1;
    check(tag, io_readdata, exp);
  endtask

  initial begin
    // 1. Reset state
    step();
    step();
    rst = 1'b0;
    check("rst_gpio_out", {24'd0, gpio_out}, 32'd0);
    check("rst_irq", {31'd0, timer_irq}, 32'd0);
    for (int i = 0; i < 7; i++) begin
      chk_rd("rst_read", 8'(i * 4), 32'd0);
    end
    datamem_add = 32'h1000_0000;
    #1;
    check("unmapped_sel", {31'd0, io_sel}, 32'd0);
    check("unmapped_rd", io_readdata, 32'd0);

    // 2. GPIO out/in
    wr(R_OUT, 32'h0000_00A5);
    check("gpio_out", {24'd0, gpio_out}, 32'h0000_00A5);
    chk_rd("gpio_out_rd", R_OUT, 32'h0000_00A5);
    gpio_in = 8'h3C;
    step();
    chk_rd("gpio_in_lag1", R_IN, 32'd0);
    step();
    chk_rd("gpio_in_lag2", R_IN, 32'h0000_003C);
    wr(8'h1C, 32'hFFFF_FFFF);
    chk_rd("unmapped_off", 8'h1C, 32'd0);
    datamem_add = 32'h1000_0000;
    write_data  = 32'd0;
    mem_write   = 1'b1;
    step();
    mem_write   = 1'b0;
    check("out_of_window_wr", {24'd0, gpio_out}, 32'h0000_00A5);

    // 3. Auto-reload, PRESCALE=0, COMPARE=4: period 5
    wr(R_PRE, 32'd0);
    wr(R_CMP, 32'd4);
    wr(R_CTL, 32'd7);
    chk_rd("ctrl_rd", R_CTL, 32'd7);
    chk_rd("ar_count0", R_CNT, 32'd0);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk_rd("ar_count", R_CNT, 32'(k % 5));
      chk_rd("ar_status", R_STS, (k >= 5) ? 32'd1 : 32'd0);
      check("ar_irq", {31'd0, timer_irq}, (k >= 5) ? 32'd1 : 32'd0);
    end
    wr(R_STS, 32'd1);
    chk_rd("ar_w1c", R_STS, 32'd0);
    check("ar_w1c_irq", {31'd0, timer_irq}, 32'd0);

    // 4. PRESCALE=2, no reload, COMPARE=1: first match 6 cycles after enable
    wr(R_CTL, 32'd0);
    wr(R_STS, 32'd1);
    wr(R_CNT, 32'd0);
    wr(R_PRE, 32'd2);
    wr(R_CMP, 32'd1);
    wr(R_CTL, 32'd5);
    for (int k = 1; k <= 9; k++) begin
      step();
      chk_rd("ps_count", R_CNT, (k < 3) ? 32'd0 : (k < 6) ? 32'd1 : (k < 9) ? 32'd2 : 32'd3);
      chk_rd("ps_status", R_STS, (k >= 6) ? 32'd1 : 32'd0);
      check("ps_irq", {31'd0, timer_irq}, (k >= 6) ? 32'd1 : 32'd0);
    end

    // 5. W1C coincident with a new match: set wins
    wr(R_CTL, 32'd0);
    wr(R_STS, 32'd1);
    wr(R_PRE, 32'd0);
    wr(R_CMP, 32'd4);
    wr(R_CNT, 32'd2);
    chk_rd("col_pre_status", R_STS, 32'd0);
    wr(R_CTL, 32'd7);
    step();
    step();
    chk_rd("col_count4", R_CNT, 32'd4);
    wr(R_STS, 32'd1);
    chk_rd("col_set_wins", R_STS, 32'd1);
    chk_rd("col_reload", R_CNT, 32'd0);
    check("col_irq", {31'd0, timer_irq}, 32'd1);
    wr(R_STS, 32'd1);
    chk_rd("col_w1c", R_STS, 32'd0);
    check("col_w1c_irq", {31'd0, timer_irq}, 32'd0);
    chk_rd("col_count1", R_CNT, 32'd1);

    // CPU COUNT write in a matching tick: written value wins, match still flagged
    step();
    step();
    step();
    chk_rd("cw_count4", R_CNT, 32'd4);
    wr(R_CNT, 32'd100);
    chk_rd("cw_count_wins", R_CNT, 32'd100);
    chk_rd("cw_match", R_STS, 32'd1);

    // 6. Wrap from all-ones without a flag, then reset mid-run
    wr(R_CTL, 32'd0);
    wr(R_STS, 32'd1);
    wr(R_CMP, 32'd5);
    wr(R_CNT, 32'hFFFF_FFFF);
    wr(R_CTL, 32'd5);
    chk_rd("wrap_pre", R_CNT, 32'hFFFF_FFFF);
    step();
    chk_rd("wrap_count", R_CNT, 32'd0);
    chk_rd("wrap_noflag", R_STS, 32'd0);
    check("wrap_irq", {31'd0, timer_irq}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
    end
    chk_rd("wrap_count5", R_CNT, 32'd5);
    step();
    check("wrap_match_irq", {31'd0, timer_irq}, 32'd1);
    rst = 1'b1;
    step();
    check("mid_rst_irq", {31'd0, timer_irq}, 32'd0);
    check("mid_rst_gpio", {24'd0, gpio_out}, 32'd0);
    chk_rd("mid_rst_count", R_CNT, 32'd0);
    chk_rd("mid_rst_status", R_STS, 32'd0);
    chk_rd("mid_rst_ctrl", R_CTL, 32'd0);
    chk_rd("mid_rst_cmp", R_CMP, 32'd0);
    chk_rd("mid_rst_pre", R_PRE, 32'd0);
    rst = 1'b0;
    step();
    chk_rd("post_rst_count", R_CNT, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
